// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit: funct3 encodings,
// FSM states, byte-enable generation and alignment/legality checks.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3[1:0])
            2'b00:   be_gen = 4'b0001 << addr;
            2'b01:   be_gen = addr[1] ? 4'b1100 : 4'b0011;
            default: be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        misaligned = (funct3[0] & addr[0]) | ((funct3[1:0] == 2'b10) & (addr != 2'b00));
    endfunction

    // Loads allow B/H/W/BU/HU; stores allow only B/H/W.
    function automatic logic illegal(input logic is_load, input logic [2:0] funct3);
        if (is_load) illegal = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
        else         illegal = (funct3 >= 3'b011);
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign- or
// zero-extends it according to the load funct3.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data = {24'h0, shifted[7:0]};
            F3_HU:   data = {16'h0, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: issues one load or store over a req/gnt/rvalid port,
// stalls the pipeline while it is in flight and hands load data to writeback.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [2:0]        ex_funct3,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [4:0]        ex_rd,
    output logic              stall,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata
);

    lsu_state_t        state;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;

    logic              op_present;
    logic              op_bad;
    logic              accept;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] load_data;

    always_comb begin
        op_present = ex_valid & (ex_load | ex_store);
        op_bad     = (ex_load & ex_store) | illegal(ex_load, ex_funct3)
                   | misaligned(ex_funct3, ex_addr[1:0]);
        accept     = (state == IDLE) & op_present & ~op_bad;
        case (ex_funct3[1:0])
            2'b00:   wdata_rep = {4{ex_wdata[7:0]}};
            2'b01:   wdata_rep = {2{ex_wdata[15:0]}};
            default: wdata_rep = ex_wdata;
        endcase
    end

    load_align u_align (
        .rdata  (dmem_rdata),
        .addr   (addr_q[1:0]),
        .funct3 (f3_q),
        .data   (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= ex_addr;
                        f3_q    <= ex_funct3;
                        rd_q    <= ex_rd;
                        we_q    <= ex_store;
                        be_q    <= be_gen(ex_funct3, ex_addr[1:0]);
                        wdata_q <= wdata_rep;
                        state   <= REQ;
                    end else if (op_present & op_bad) begin
                        fault      <= 1'b1;
                        fault_addr <= ex_addr;
                    end
                end
                REQ: begin
                    if (dmem_gnt) state <= we_q ? DONE : RESP;
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        data_q <= load_data;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Gating with rst keeps stall low while reset is held, even if an op is presented.
    assign stall      = ~rst & (accept | (state == REQ) | (state == RESP));
    assign dmem_req   = (state == REQ);
    assign dmem_we    = we_q;
    assign dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign wb_valid   = (state == DONE) & ~we_q & (rd_q != 5'd0);
    assign wb_rd      = rd_q;
    assign wb_data    = data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset
// mid-operation sequence, and randomized ops checked against a reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_load, ex_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        stall, wb_valid, fault, dmem_req, dmem_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, fault_addr, dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;

    int checks = 0;
    int errors = 0;
    logic noise = 1'b0;

    typedef struct {
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        logic [4:0]  rd;
        int          gw, rw;
        logic        x_fault;
        logic [3:0]  x_be;
        logic [31:0] x_wdata;
        logic        x_wb;
        logic [31:0] x_data;
        int          x_cyc;
    } vec_t;

    load_store_unit dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .fault(fault), .fault_addr(fault_addr), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic [4:0] rd,
                                input int gw, input int rw, input logic xf, input logic [3:0] xbe,
                                input logic [31:0] xwd, input logic xwb, input logic [31:0] xdata,
                                input int xcyc);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.rd = rd; v.gw = gw; v.rw = rw; v.x_fault = xf; v.x_be = xbe; v.x_wdata = xwd;
        v.x_wb = xwb; v.x_data = xdata; v.x_cyc = xcyc;
        return v;
    endfunction

    // Reference model: derives expectations from access size, offset and signedness.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int size, off;
        logic legal;
        logic [31:0] mask, val;
        r = v;
        off = int'(v.addr[1:0]);
        size = 1 << int'(v.f3[1:0]);
        legal = v.ld ? (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (v.f3 <= 3'd2);
        r.x_fault = (v.ld & v.st) | !legal | ((off % size) != 0);
        r.x_be = 4'(((1 << size) - 1) << off);
        if (size == 1)      r.x_wdata = {24'h0, v.wdata[7:0]} * 32'h0101_0101;
        else if (size == 2) r.x_wdata = {16'h0, v.wdata[15:0]} * 32'h0001_0001;
        else                r.x_wdata = v.wdata;
        mask = (size >= 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * size)) - 1);
        val = (v.rdata >> (8 * off)) & mask;
        if (!v.f3[2] && size < 4 && val[8 * size - 1]) val = val | ~mask;
        r.x_data = val;
        r.x_wb = v.ld & !r.x_fault & (v.rd != 5'd0);
        r.x_cyc = v.st ? 3 + v.gw : 4 + v.gw + v.rw;
        return r;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int cyc, g, r;
        logic granted, done;
        @(negedge clk);
        ex_valid = 1'b1; ex_load = v.ld; ex_store = v.st; ex_funct3 = v.f3;
        ex_addr = v.addr; ex_wdata = v.wdata; ex_rd = v.rd;
        dmem_gnt = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        dmem_rvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        dmem_rdata = $urandom;
        #1;
        cyc = 1;
        chk({tag, " accept stall"}, 32'(stall), 32'(!v.x_fault));
        chk({tag, " accept req"}, 32'(dmem_req), 32'd0);
        if (v.x_fault) begin
            @(negedge clk);
            ex_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            #1;
            chk({tag, " fault"}, 32'(fault), 32'd1);
            chk({tag, " fault_addr"}, fault_addr, v.addr);
            chk({tag, " fault req"}, 32'(dmem_req), 32'd0);
            chk({tag, " fault stall"}, 32'(stall), 32'd0);
            chk({tag, " fault wb"}, 32'(wb_valid), 32'd0);
            @(negedge clk);
            #1;
            chk({tag, " fault pulse"}, 32'(fault), 32'd0);
            return;
        end
        g = 0; r = 0; granted = 1'b0; done = 1'b0;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
            #1;
            cyc++;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            if (!granted) begin
                chk({tag, " req"}, 32'(dmem_req), 32'd1);
                chk({tag, " we"}, 32'(dmem_we), 32'(v.st));
                chk({tag, " addr"}, dmem_addr, {v.addr[31:2], 2'b00});
                chk({tag, " be"}, 32'(dmem_be), 32'(v.x_be));
                if (v.st) chk({tag, " wdata"}, dmem_wdata, v.x_wdata);
                if (g == v.gw) begin
                    dmem_gnt = 1'b1;
                    granted = 1'b1;
                end else if (noise) begin
                    dmem_rvalid = 1'($urandom_range(0, 1));
                end
                g++;
            end else begin
                chk({tag, " req drop"}, 32'(dmem_req), 32'd0);
                if (r == v.rw) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata = v.rdata;
                end
                r++;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: no completion within 64 cycles", tag);
            return;
        end
        if (noise) begin
            dmem_gnt = 1'($urandom_range(0, 1));
            dmem_rvalid = 1'($urandom_range(0, 1));
        end
        chk({tag, " latency"}, 32'(cyc), 32'(v.x_cyc));
        chk({tag, " done req"}, 32'(dmem_req), 32'd0);
        chk({tag, " wb_valid"}, 32'(wb_valid), 32'(v.x_wb));
        if (v.x_wb) begin
            chk({tag, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
            chk({tag, " wb_data"}, wb_data, v.x_data);
        end
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'b0;
        ex_addr = '0; ex_wdata = '0; ex_rd = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        #1;
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst req", 32'(dmem_req), 32'd0);
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst fault", 32'(fault), 32'd0);
        chk("rst dmem_be", 32'(dmem_be), 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        tbl.push_back(mk(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 4'hF, 32'hDEADBEEF, 0, 0, 3));
        tbl.push_back(mk(1, 0, 3'd0, 32'h203, 0, 32'h8000_0000, 5, 0, 0, 0, 4'h8, 0, 1, 32'hFFFF_FF80, 4));
        tbl.push_back(mk(1, 0, 3'd4, 32'h203, 0, 32'h8000_0000, 6, 0, 0, 0, 4'h8, 0, 1, 32'h0000_0080, 4));
        tbl.push_back(mk(1, 0, 3'd5, 32'h202, 0, 32'hBEEF_1234, 9, 0, 0, 0, 4'hC, 0, 1, 32'h0000_BEEF, 4));
        tbl.push_back(mk(0, 1, 3'd1, 32'h101, 32'h1234, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 3'd3, 32'h200, 0, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'd0, 32'h0E, 32'hAB, 0, 0, 3, 0, 0, 4'h4, 32'hABAB_ABAB, 0, 0, 6));
        tbl.push_back(mk(1, 0, 3'd1, 32'h206, 0, 32'h8001_1234, 12, 1, 2, 0, 4'hC, 0, 1, 32'hFFFF_8001, 7));
        tbl.push_back(mk(1, 0, 3'd2, 32'h10, 0, 32'h1234_5678, 0, 0, 0, 0, 4'hF, 0, 0, 0, 4));
        tbl.push_back(mk(1, 1, 3'd2, 32'h20, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'd3, 32'h24, 32'h55, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 3'd2, 32'h102, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'd1, 32'h2A, 32'h5555_C3D4, 0, 0, 0, 0, 0, 4'hC, 32'hC3D4_C3D4, 0, 0, 3));
        tbl.push_back(mk(1, 0, 3'd0, 32'h41, 0, 32'h0000_7F00, 2, 0, 1, 0, 4'h2, 0, 1, 32'h0000_007F, 5));
        foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

        // Reset while a load waits in RESP.
        @(negedge clk);
        ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'd2;
        ex_addr = 32'h300; ex_rd = 5'd7; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        @(negedge clk);
        #1;
        chk("rstseq req", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        chk("rstseq resp stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstseq stall", 32'(stall), 32'd0);
        chk("rstseq req drop", 32'(dmem_req), 32'd0);
        chk("rstseq wb_valid", 32'(wb_valid), 32'd0);
        chk("rstseq wb_data", wb_data, 32'd0);
        ex_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        #1;
        chk("rstseq late stall", 32'(stall), 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        chk("rstseq late wb", 32'(wb_valid), 32'd0);
        chk("rstseq late req", 32'(dmem_req), 32'd0);
        run_op(mk(1, 0, 3'd2, 32'h40, 0, 32'hCAFE_F00D, 3, 0, 0, 0, 4'hF, 0, 1, 32'hCAFE_F00D, 4), "post_rst_lw");

        noise = 1'b1;
        for (int i = 0; i < 60; i++) begin
            rv.ld = 1'($urandom_range(0, 1));
            rv.st = ($urandom_range(0, 9) == 0) ? 1'b1 : !rv.ld;
            rv.f3 = 3'($urandom_range(0, 7));
            rv.addr = $urandom;
            rv.wdata = $urandom;
            rv.rdata = $urandom;
            rv.rd = 5'($urandom_range(0, 31));
            rv.gw = $urandom_range(0, 2);
            rv.rw = $urandom_range(0, 2);
            run_op(model(rv), $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        ex_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        #1;
        chk("final idle stall", 32'(stall), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
